mem_port_arbiter: RTL and testbench

//   Shares one single-ported, fixed-latency word memory between the instruction

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the unified-RAM port arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [29:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU, with bounded LSU
// priority and a fixed-latency owner tag pipe that routes read responses back.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int MAX_LS_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LS_RUN   = 2'd1;
  localparam logic [1:0] S_IF_FORCE = 2'd2;
  localparam logic [3:0] RUN_MAX    = 4'(MAX_LS_RUN);

  logic [1:0]         state_q, state_d;
  logic [3:0]         ls_run_q, ls_run_d;
  logic               arb_if, arb_ls;
  logic               gnt_if, gnt_ls;
  logic               push_vld, push_own;
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;

  // Arbitration: LSU wins by default; after MAX_LS_RUN+1 back-to-back LSU grants
  // against a waiting fetch, the IF_FORCE state hands the next slot to fetch.
  always_comb begin
    state_d  = state_q;
    ls_run_d = ls_run_q;
    arb_if   = 1'b0;
    arb_ls   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ls_run_d = '0;
        if (bus.ls_req) begin
          arb_ls = 1'b1;
          if (bus.if_req) state_d = S_LS_RUN;
        end else begin
          arb_if = bus.if_req;
        end
      end
      S_LS_RUN: begin
        if (!bus.ls_req) begin
          arb_if   = bus.if_req;
          state_d  = S_IDLE;
          ls_run_d = '0;
        end else if (!bus.if_req) begin
          arb_ls   = 1'b1;
          state_d  = S_IDLE;
          ls_run_d = '0;
        end else if (ls_run_q < RUN_MAX) begin
          arb_ls   = 1'b1;
          ls_run_d = ls_run_q + 4'd1;
          if (ls_run_q + 4'd1 == RUN_MAX) state_d = S_IF_FORCE;
        end else begin
          arb_if   = 1'b1;
          state_d  = S_IDLE;
          ls_run_d = '0;
        end
      end
      S_IF_FORCE: begin
        arb_if   = bus.if_req;
        state_d  = S_IDLE;
        ls_run_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        ls_run_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ls_run_q <= '0;
    end else begin
      state_q  <= state_d;
      ls_run_q <= ls_run_d;
    end
  end

  // Grants are forced low while reset is asserted, independent of requests.
  assign gnt_if = arb_if & rst_n;
  assign gnt_ls = arb_ls & rst_n;

  assign bus.if_gnt    = gnt_if;
  assign bus.ls_gnt    = gnt_ls;
  assign bus.mem_en    = gnt_if | gnt_ls;
  assign bus.mem_we    = (gnt_ls && bus.ls_we) ? bus.ls_be : 4'b0000;
  assign bus.mem_addr  = gnt_ls ? bus.ls_addr : bus.if_addr;
  assign bus.mem_wdata = bus.ls_wdata;

  // Tag pipe: one entry per memory slot, so the tail lines up with mem_rdata.
  assign push_vld = gnt_if | (gnt_ls & ~bus.ls_we);
  assign push_own = gnt_ls;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = push_vld;
    tag_own_d[0] = push_own;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign bus.if_rvalid = tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
  assign bus.ls_rvalid = tag_vld_q[MEM_LAT-1] &  tag_own_q[MEM_LAT-1];
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share requester inputs and
// are compared every cycle against a grant-streak / response-schedule reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int MAXR  = 4;
  localparam int NCYC  = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if a ();
  mem_port_arbiter_if b ();

  mem_port_arbiter #(.MEM_LAT(LAT_A), .MAX_LS_RUN(MAXR)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave));
  mem_port_arbiter #(.MEM_LAT(LAT_B), .MAX_LS_RUN(MAXR)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));

  assign b.if_req   = a.if_req;
  assign b.if_addr  = a.if_addr;
  assign b.ls_req   = a.ls_req;
  assign b.ls_we    = a.ls_we;
  assign b.ls_be    = a.ls_be;
  assign b.ls_addr  = a.ls_addr;
  assign b.ls_wdata = a.ls_wdata;

  // Environment RAM (written from DUT a's memory port) and its read-data delay line.
  logic [31:0] ram [256];
  logic [31:0] rd_now, rd_p0, rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p0 <= rd_now;
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
  end
  assign a.mem_rdata = rd_p0;
  assign b.mem_rdata = rd_p2;

  // Reference state: architectural shadow memory and the expected response schedule.
  logic [31:0] sh [256];
  logic        exp_av [NCYC];
  logic        exp_ao [NCYC];
  logic [31:0] exp_ad [NCYC];
  logic        exp_bv [NCYC];
  logic        exp_bo [NCYC];
  logic [31:0] exp_bd [NCYC];

  int cyc, streak, ntests, nfail;
  logic        last_ifg, last_lsg;
  logic [3:0]  last_we;
  logic [31:0] last_wd;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string pfx, input logic ig, input logic lg,
                            input logic mem_en, input logic [3:0] mem_we,
                            input logic [29:0] mem_addr, input logic [31:0] mem_wdata,
                            input logic eg_if, input logic eg_ls,
                            input logic [29:0] ia, input logic [29:0] la,
                            input logic we, input logic [3:0] be, input logic [31:0] wd);
    check({pfx, "_if_gnt"}, ig, eg_if);
    check({pfx, "_ls_gnt"}, lg, eg_ls);
    check({pfx, "_mem_en"}, mem_en, eg_if | eg_ls);
    check({pfx, "_mem_we"}, mem_we, (eg_ls && we) ? be : 4'b0000);
    if (eg_if) check({pfx, "_mem_addr_if"}, mem_addr, ia);
    if (eg_ls) check({pfx, "_mem_addr_ls"}, mem_addr, la);
    if (eg_ls && we) check({pfx, "_mem_wdata"}, mem_wdata, wd);
  endtask

  task automatic check_resp(input string pfx, input logic irv, input logic lrv,
                            input logic [31:0] ird, input logic [31:0] lrd,
                            input logic ev, input logic eo, input logic [31:0] ed);
    check({pfx, "_if_rvalid"}, irv, ev & ~eo);
    check({pfx, "_ls_rvalid"}, lrv, ev & eo);
    check({pfx, "_rv_excl"}, irv & lrv, 1'b0);
    if (ev) check({pfx, "_rdata"}, eo ? lrd : ird, ed);
  endtask

  // One clock cycle: predict grants, compare both DUTs, advance model and environment.
  task automatic step(output logic g_if, output logic g_ls);
    logic ifr, lsr, we;
    logic [29:0] ia, la, ra;
    logic [3:0] be;
    logic [31:0] wd;
    @(negedge clk);
    ifr = a.if_req; lsr = a.ls_req; we = a.ls_we; be = a.ls_be;
    ia = a.if_addr; la = a.ls_addr; wd = a.ls_wdata;
    g_if = 1'b0; g_ls = 1'b0;
    if (rst_n) begin
      if (streak == MAXR + 1) begin
        g_if = ifr; streak = 0;
      end else if (lsr) begin
        g_ls = 1'b1; streak = ifr ? streak + 1 : 0;
      end else begin
        g_if = ifr; streak = 0;
      end
    end
    last_ifg = a.if_gnt; last_lsg = a.ls_gnt; last_we = a.mem_we; last_wd = a.mem_wdata;
    check_port("a", a.if_gnt, a.ls_gnt, a.mem_en, a.mem_we, a.mem_addr, a.mem_wdata,
               g_if, g_ls, ia, la, we, be, wd);
    check_port("b", b.if_gnt, b.ls_gnt, b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata,
               g_if, g_ls, ia, la, we, be, wd);
    check_resp("a", a.if_rvalid, a.ls_rvalid, a.if_rdata, a.ls_rdata,
               exp_av[cyc], exp_ao[cyc], exp_ad[cyc]);
    check_resp("b", b.if_rvalid, b.ls_rvalid, b.if_rdata, b.ls_rdata,
               exp_bv[cyc], exp_bo[cyc], exp_bd[cyc]);
    if (a.mem_en) begin
      rd_now = ram[a.mem_addr[7:0]];
      ram[a.mem_addr[7:0]] = merge(ram[a.mem_addr[7:0]], a.mem_wdata, a.mem_we);
    end else begin
      rd_now = $urandom();
    end
    if (g_if || (g_ls && !we)) begin
      ra = g_if ? ia : la;
      exp_av[cyc+LAT_A] = 1'b1; exp_ao[cyc+LAT_A] = g_ls; exp_ad[cyc+LAT_A] = sh[ra[7:0]];
      exp_bv[cyc+LAT_B] = 1'b1; exp_bo[cyc+LAT_B] = g_ls; exp_bd[cyc+LAT_B] = sh[ra[7:0]];
    end
    if (g_ls && we) sh[la[7:0]] = merge(sh[la[7:0]], wd, be);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_midcycle();
    #3 rst_n = 1'b0;
    #1;
    check("rst_a_if_gnt", a.if_gnt, 1'b0);
    check("rst_a_ls_gnt", a.ls_gnt, 1'b0);
    check("rst_a_mem_en", a.mem_en, 1'b0);
    check("rst_a_mem_we", a.mem_we, 4'b0000);
    check("rst_b_if_rvalid", b.if_rvalid, 1'b0);
    check("rst_b_ls_rvalid", b.ls_rvalid, 1'b0);
    check("rst_b_mem_en", b.mem_en, 1'b0);
    streak = 0;
    for (int k = cyc; k < NCYC; k++) begin
      exp_av[k] = 1'b0;
      exp_bv[k] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    a.if_req = 1'b0; a.ls_req = 1'b0; a.ls_we = 1'b0; a.ls_be = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gi, gl;
    logic [9:0] pat;
    int cnt;
    ntests = 0; nfail = 0; cyc = 0; streak = 0; rd_now = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'(32'h9E3779B9 * (i + 1));
      sh[i]  = ram[i];
    end
    for (int k = 0; k < NCYC; k++) begin
      exp_av[k] = 1'b0; exp_ao[k] = 1'b0; exp_ad[k] = '0;
      exp_bv[k] = 1'b0; exp_bo[k] = 1'b0; exp_bd[k] = '0;
    end
    rst_n = 1'b0;
    idle_inputs();
    a.if_addr = '0; a.ls_addr = '0; a.ls_wdata = '0;
    step(gi, gl); step(gi, gl);
    rst_n = 1'b1;
    step(gi, gl);

    // Fetch only: three back-to-back grants at 0x50.
    a.if_req = 1'b1; a.if_addr = 30'h50;
    cnt = 0;
    for (int n = 0; n < 3; n++) begin step(gi, gl); cnt += int'(last_ifg); end
    check("t1_if_gnt_count", cnt, 3);
    idle_inputs();
    step(gi, gl); step(gi, gl);

    // Simultaneous requests from IDLE: LSU read first, fetch next cycle.
    a.if_req = 1'b1; a.if_addr = 30'h20;
    a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_addr = 30'h21;
    step(gi, gl);
    check("t2_ls_first", {last_ifg, last_lsg}, 2'b01);
    a.ls_req = 1'b0;
    step(gi, gl);
    idle_inputs();
    for (int n = 0; n < 4; n++) step(gi, gl);

    // Starvation bound with both requesters saturating.
    a.if_req = 1'b1; a.if_addr = 30'h30;
    a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_addr = 30'h31;
    pat = '0;
    for (int n = 0; n < 10; n++) begin step(gi, gl); pat = {pat[8:0], last_lsg}; end
    check("t3_grant_pattern", pat, 10'b1111101111);
    idle_inputs();
    for (int n = 0; n < 4; n++) step(gi, gl);

    // Partial-byte write, zero-strobe write, then read-back.
    a.ls_req = 1'b1; a.ls_we = 1'b1; a.ls_be = 4'b0110;
    a.ls_addr = 30'h10; a.ls_wdata = 32'hDEADBEEF;
    step(gi, gl);
    check("t4_mem_we", last_we, 4'b0110);
    check("t4_mem_wdata", last_wd, 32'hDEADBEEF);
    check("t4_ls_gnt", last_lsg, 1'b1);
    a.ls_be = 4'b0000; a.ls_wdata = 32'h12345678;
    step(gi, gl);
    a.ls_we = 1'b0;
    step(gi, gl);
    idle_inputs();
    for (int n = 0; n < 4; n++) step(gi, gl);

    // Alternating single-cycle fetch / LSU reads.
    for (int n = 0; n < 8; n++) begin
      a.if_req = (n % 2 == 0); a.if_addr = 30'(n + 8);
      a.ls_req = (n % 2 == 1); a.ls_we = 1'b0; a.ls_addr = 30'(n + 0);
      step(gi, gl);
    end
    idle_inputs();
    for (int n = 0; n < 4; n++) step(gi, gl);

    // Reset with two reads in flight on the latency-3 instance.
    a.if_req = 1'b1; a.if_addr = 30'h3;
    step(gi, gl);
    a.if_req = 1'b0; a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_addr = 30'h4;
    step(gi, gl);
    a.if_req = 1'b1; a.if_addr = 30'h5; a.ls_addr = 30'h6;
    reset_midcycle();
    step(gi, gl); step(gi, gl);
    rst_n = 1'b1;
    step(gi, gl);
    check("t6_first_gnt_ls", {last_ifg, last_lsg}, 2'b01);
    a.ls_req = 1'b0;
    step(gi, gl);
    idle_inputs();
    for (int n = 0; n < 4; n++) step(gi, gl);

    // Randomised traffic honouring hold-until-grant, with one reset in the middle.
    gi = 1'b0; gl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!a.if_req || gi) begin
        a.if_req  = ($urandom_range(0, 3) != 0);
        a.if_addr = $urandom_range(0, 1) ? 30'($urandom_range(0, 15)) : 30'($urandom());
      end
      if (!a.ls_req || gl) begin
        a.ls_req   = ($urandom_range(0, 3) != 0);
        a.ls_we    = 1'($urandom_range(0, 1));
        a.ls_be    = 4'($urandom());
        a.ls_addr  = $urandom_range(0, 1) ? 30'($urandom_range(0, 15)) : 30'($urandom());
        a.ls_wdata = $urandom();
      end
      step(gi, gl);
      if (n == 200) begin
        reset_midcycle();
        step(gi, gl); step(gi, gl);
        rst_n = 1'b1;
      end
    end
    idle_inputs();
    for (int n = 0; n < 5; n++) step(gi, gl);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
